// File: rtl/dpwm_config_controller.sv
// Button-driven frequency/duty index controller for the DPWM datapath, with
// hold-to-auto-repeat stepping and a soft-start ramp on the applied duty.
module dpwm_config_controller #(
    parameter int FREQ_MAX      = 9,
    parameter int DUTY_MAX      = 9,
    parameter int FREQ_RESET    = 0,
    parameter int DUTY_RESET    = 5,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int RAMP_CYCLES   = 1_000_000
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       up,
    input  logic       down,
    input  logic       funct_select,
    output logic [3:0] freq_index,
    output logic [3:0] duty_index,
    output logic [3:0] duty_applied,
    output logic       ramping,
    output logic       update_strobe
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES)
                           ? ((HOLD_CYCLES > RAMP_CYCLES) ? HOLD_CYCLES : RAMP_CYCLES)
                           : ((REPEAT_CYCLES > RAMP_CYCLES) ? REPEAT_CYCLES : RAMP_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [3:0]         freq_q, freq_d;
    logic [3:0]         duty_q, duty_d;
    logic [3:0]         applied_q, applied_d;
    logic               ramping_q, ramping_d;
    logic               strobe_q, strobe_d;
    logic               up_prev_q, down_prev_q;
    logic               dir_up_q, dir_up_d;
    logic               fsel_q, fsel_d;
    logic               started_q;

    logic               press_up, press_down, abort;
    logic               do_step, step_up, step_sel;

    function automatic logic [3:0] sat_step(input logic [3:0] v, input logic inc,
                                            input logic [3:0] lim);
        if (inc) return (v >= lim) ? v : v + 4'd1;
        else     return (v == 4'd0) ? v : v - 4'd1;
    endfunction

    // A press counts only on the cycle a button is first seen high, alone.
    assign press_up   = up & ~down & ~up_prev_q;
    assign press_down = down & ~up & ~down_prev_q;
    assign abort      = (dir_up_q ? ~up : ~down) | (up & down) | (funct_select != fsel_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        freq_d   = freq_q;
        duty_d   = duty_q;
        dir_up_d = dir_up_q;
        fsel_d   = fsel_q;
        do_step  = 1'b0;
        step_up  = dir_up_q;
        step_sel = fsel_q;

        case (state_q)
            IDLE: begin
                if (press_up || press_down) begin
                    do_step  = 1'b1;
                    step_up  = press_up;
                    step_sel = funct_select;
                    dir_up_d = press_up;
                    fsel_d   = funct_select;
                    cnt_d    = CNT_W'(HOLD_CYCLES - 1);
                    state_d  = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    do_step = 1'b1;
                    cnt_d   = CNT_W'(REPEAT_CYCLES - 1);
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_step) begin
            if (step_sel) duty_d = sat_step(duty_q, step_up, 4'(DUTY_MAX));
            else          freq_d = sat_step(freq_q, step_up, 4'(FREQ_MAX));
        end

        strobe_d = (freq_d != freq_q) || (duty_d != duty_q);

        // Frequency change (or first cycle out of reset) overrides any ramp activity.
        applied_d  = applied_q;
        ramp_cnt_d = ramp_cnt_q;
        if (!started_q || (freq_d != freq_q)) begin
            applied_d  = 4'd0;
            ramp_cnt_d = '0;
        end else if (duty_d < applied_q) begin
            applied_d  = duty_d;
            ramp_cnt_d = '0;
        end else if (applied_q < duty_q) begin
            if (ramp_cnt_q == CNT_W'(RAMP_CYCLES - 1)) begin
                applied_d  = applied_q + 4'd1;
                ramp_cnt_d = '0;
            end else begin
                ramp_cnt_d = ramp_cnt_q + CNT_W'(1);
            end
        end else begin
            ramp_cnt_d = '0;
        end

        ramping_d = (applied_q < duty_q);
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ramp_cnt_q  <= '0;
            freq_q      <= 4'(FREQ_RESET);
            duty_q      <= 4'(DUTY_RESET);
            applied_q   <= 4'd0;
            ramping_q   <= 1'b0;
            strobe_q    <= 1'b0;
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
            dir_up_q    <= 1'b0;
            fsel_q      <= 1'b0;
            started_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ramp_cnt_q  <= ramp_cnt_d;
            freq_q      <= freq_d;
            duty_q      <= duty_d;
            applied_q   <= applied_d;
            ramping_q   <= ramping_d;
            strobe_q    <= strobe_d;
            up_prev_q   <= up;
            down_prev_q <= down;
            dir_up_q    <= dir_up_d;
            fsel_q      <= fsel_d;
            started_q   <= 1'b1;
        end
    end

    assign freq_index    = freq_q;
    assign duty_index    = duty_q;
    assign duty_applied  = applied_q;
    assign ramping       = ramping_q;
    assign update_strobe = strobe_q;

endmodule

// File: tb/tb_dpwm_config_controller.sv
// Directed bench for dpwm_config_controller: expected index pairs are queued on
// each press and popped by a monitor on every update_strobe.
module tb_dpwm_config_controller;

    logic       clk_100MHz = 1'b0;
    logic       rst_n;
    logic       up, down, funct_select;
    logic [3:0] freq_index, duty_index, duty_applied;
    logic       ramping, update_strobe;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    dpwm_config_controller #(
        .FREQ_MAX(9), .DUTY_MAX(9), .FREQ_RESET(0), .DUTY_RESET(5),
        .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .RAMP_CYCLES(3)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .rst_n        (rst_n),
        .up           (up),
        .down         (down),
        .funct_select (funct_select),
        .freq_index   (freq_index),
        .duty_index   (duty_index),
        .duty_applied (duty_applied),
        .ramping      (ramping),
        .update_strobe(update_strobe)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk_100MHz) begin
        if (rst_n === 1'b1 && update_strobe === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got freq=%0d duty=%0d expected no strobe at %0t",
                         freq_index, duty_index, $time);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if ({freq_index, duty_index} !== e) begin
                    bad++;
                    $display("FAIL strobe_value: got freq=%0d duty=%0d expected freq=%0d duty=%0d at %0t",
                             freq_index, duty_index, e[7:4], e[3:0], $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int exp_applied[17] = '{0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,5,5};
    int exp_ramp[17]    = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};

    initial begin
        rst_n = 1'b0; up = 1'b0; down = 1'b0; funct_select = 1'b0;
        tick(2);
        check("rst_freq", freq_index, 0);
        check("rst_duty", duty_index, 5);
        check("rst_applied", duty_applied, 0);
        check("rst_ramping", ramping, 0);
        check("rst_strobe", update_strobe, 0);

        // 1: startup ramp
        rst_n = 1'b1;
        for (int e = 0; e < 17; e++) begin
            tick(1);
            check($sformatf("t1_applied_e%0d", e), duty_applied, exp_applied[e]);
            check($sformatf("t1_ramping_e%0d", e), ramping, exp_ramp[e]);
        end
        check("t1_freq", freq_index, 0);

        // 2: single frequency step restarts the ramp
        funct_select = 1'b0; up = 1'b1;
        sb.push_back({4'd1, 4'd5});
        tick(1);
        check("t2_freq", freq_index, 1);
        check("t2_applied_k", duty_applied, 0);
        tick(1);
        up = 1'b0;
        tick(1);
        check("t2_applied_k2", duty_applied, 0);
        tick(1);
        check("t2_applied_k3", duty_applied, 1);
        check("t2_ramping_k3", ramping, 1);
        tick(12);
        check("t2_applied_k15", duty_applied, 5);
        tick(1);
        check("t2_ramping_k16", ramping, 0);

        // 3: held up on duty auto-repeats and saturates
        funct_select = 1'b1; up = 1'b1;
        sb.push_back({4'd1, 4'd6});
        sb.push_back({4'd1, 4'd7});
        sb.push_back({4'd1, 4'd8});
        sb.push_back({4'd1, 4'd9});
        tick(1);
        check("t3_duty_m", duty_index, 6);
        tick(7);
        check("t3_duty_m7", duty_index, 6);
        tick(1);
        check("t3_duty_m8", duty_index, 7);
        tick(4);
        check("t3_duty_m12", duty_index, 8);
        tick(4);
        check("t3_duty_m16", duty_index, 9);
        tick(4);
        check("t3_duty_m20", duty_index, 9);
        check("t3_strobe_m20", update_strobe, 0);
        up = 1'b0;
        tick(2);
        check("t3_applied", duty_applied, 9);
        check("t3_ramping", ramping, 0);

        // 4: three down presses, applied duty follows without ramping
        for (int i = 0; i < 3; i++) begin
            sb.push_back({4'd1, 4'(8 - i)});
            down = 1'b1;
            tick(1);
            check($sformatf("t4_duty_%0d", i), duty_index, 8 - i);
            check($sformatf("t4_applied_%0d", i), duty_applied, 8 - i);
            check($sformatf("t4_ramping_%0d", i), ramping, 0);
            down = 1'b0;
            tick(1);
            check($sformatf("t4_ramping_rel_%0d", i), ramping, 0);
        end

        // 5: both buttons ignored; select toggle aborts repeat; fresh press hits freq
        up = 1'b1; down = 1'b1;
        tick(3);
        check("t5_both_duty", duty_index, 6);
        check("t5_both_freq", freq_index, 1);
        up = 1'b0; down = 1'b0;
        tick(1);
        up = 1'b1;
        sb.push_back({4'd1, 4'd7});
        tick(1);
        check("t5_duty_q", duty_index, 7);
        tick(3);
        funct_select = 1'b0;
        tick(10);
        check("t5_abort_duty", duty_index, 7);
        check("t5_abort_freq", freq_index, 1);
        up = 1'b0;
        tick(1);
        up = 1'b1;
        sb.push_back({4'd2, 4'd7});
        tick(1);
        check("t5_fresh_freq", freq_index, 2);
        check("t5_fresh_applied", duty_applied, 0);
        up = 1'b0;

        // 6: asynchronous reset in the middle of a ramp
        tick(4);
        check("t6_applied_pre", duty_applied, 1);
        check("t6_ramping_pre", ramping, 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_freq", freq_index, 0);
        check("t6_async_duty", duty_index, 5);
        check("t6_async_applied", duty_applied, 0);
        check("t6_async_ramping", ramping, 0);
        check("t6_async_strobe", update_strobe, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("t6_applied_e0", duty_applied, 0);
        tick(2);
        check("t6_applied_e2", duty_applied, 0);
        tick(1);
        check("t6_applied_e3", duty_applied, 1);
        check("t6_freq_e3", freq_index, 0);

        tick(2);
        check("sb_pending", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
